// File: rtl/game_end_timer.sv
// End-of-game pause timer: after an accepted start it runs for DURATION ticks of PRESCALE cycles,
// then pulses expired. It also keeps saturating win/loss tallies of finished games.
module game_end_timer #(
    parameter int unsigned PRESCALE = 1000000,
    parameter int unsigned DURATION = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       game_won,
    input  logic       clear_score,
    output logic       running,
    output logic       expired,
    output logic [7:0] ticks_left,
    output logic [7:0] win_count,
    output logic [7:0] loss_count
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = 8;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] DURATION_LOAD = CW'(DURATION);
    localparam logic [CW-1:0] COUNT_MAX     = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] prescaler, prescaler_nxt;
    logic [CW-1:0] ticks_nxt, win_nxt, loss_nxt;
    logic          running_nxt, expired_nxt;
    logic          first_edge, start_prev;
    logic          start_accept, tick;

    // Unreset history of start: lets the first edge after reset reject a start held through reset.
    always_ff @(posedge clk) begin
        start_prev <= start;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prescaler  <= '0;
            ticks_left <= '0;
            win_count  <= '0;
            loss_count <= '0;
            running    <= 1'b0;
            expired    <= 1'b0;
            first_edge <= 1'b1;
        end else begin
            state      <= state_nxt;
            prescaler  <= prescaler_nxt;
            ticks_left <= ticks_nxt;
            win_count  <= win_nxt;
            loss_count <= loss_nxt;
            running    <= running_nxt;
            expired    <= expired_nxt;
            first_edge <= 1'b0;
        end
    end

    // Next-state, timer and score update.
    always_comb begin
        state_nxt     = state;
        prescaler_nxt = prescaler;
        ticks_nxt     = ticks_left;
        win_nxt       = win_count;
        loss_nxt      = loss_count;
        expired_nxt   = 1'b0;
        start_accept  = 1'b0;
        tick          = 1'b0;

        case (state)
            IDLE: begin
                prescaler_nxt = '0;
                ticks_nxt     = '0;
                if (start && !(first_edge && start_prev)) begin
                    start_accept = 1'b1;
                    state_nxt    = RUN;
                    ticks_nxt    = DURATION_LOAD;
                end
            end
            RUN: begin
                tick          = (prescaler == PRESCALE_LAST);
                prescaler_nxt = tick ? '0 : prescaler + PW'(1);
                if (tick) begin
                    ticks_nxt = ticks_left - CW'(1);
                    if (ticks_left == CW'(1)) begin
                        state_nxt   = IDLE;
                        expired_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A clear wins over the result of a start in the same cycle.
        if (clear_score) begin
            win_nxt  = '0;
            loss_nxt = '0;
        end else if (start_accept) begin
            if (game_won) begin
                if (win_count != COUNT_MAX) win_nxt = win_count + CW'(1);
            end else begin
                if (loss_count != COUNT_MAX) loss_nxt = loss_count + CW'(1);
            end
        end

        running_nxt = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_game_end_timer.sv
// Bench for game_end_timer: two instances (P=4,D=3 and P=1,D=1) checked every cycle against
// a remaining-cycles model, plus directed scenarios with literal expectations.
module tb_game_end_timer;

    localparam int NI = 2;

    function automatic int p_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int d_of(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start       [NI];
    logic       game_won    [NI];
    logic       clear_score [NI];
    logic       running     [NI];
    logic       expired     [NI];
    logic [7:0] ticks_left  [NI];
    logic [7:0] win_count   [NI];
    logic [7:0] loss_count  [NI];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    game_end_timer #(.PRESCALE(4), .DURATION(3)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .game_won(game_won[0]),
        .clear_score(clear_score[0]), .running(running[0]), .expired(expired[0]),
        .ticks_left(ticks_left[0]), .win_count(win_count[0]), .loss_count(loss_count[0])
    );

    game_end_timer #(.PRESCALE(1), .DURATION(1)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .game_won(game_won[1]),
        .clear_score(clear_score[1]), .running(running[1]), .expired(expired[1]),
        .ticks_left(ticks_left[1]), .win_count(win_count[1]), .loss_count(loss_count[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pause is a count of remaining run cycles; ticks shown are that count rounded up to ticks.
    int m_rem  [NI];
    int m_win  [NI];
    int m_loss [NI];
    bit m_exp  [NI];
    bit m_sp   [NI];
    bit m_first;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                m_rem[i]  = 0;
                m_win[i]  = 0;
                m_loss[i] = 0;
                m_exp[i]  = 1'b0;
                m_sp[i]   = start[i];
            end
            m_first = 1'b1;
        end else begin
            for (int i = 0; i < NI; i++) begin
                bit acc;
                acc = (m_rem[i] == 0) && start[i] && !(m_first && m_sp[i]);
                m_exp[i] = (m_rem[i] == 1);
                if (m_rem[i] > 0) m_rem[i]--;
                else if (acc) m_rem[i] = d_of(i) * p_of(i);
                if (clear_score[i]) begin
                    m_win[i]  = 0;
                    m_loss[i] = 0;
                end else if (acc) begin
                    if (game_won[i]) m_win[i] = (m_win[i] < 255) ? m_win[i] + 1 : 255;
                    else m_loss[i] = (m_loss[i] < 255) ? m_loss[i] + 1 : 255;
                end
                m_sp[i] = start[i];
            end
            m_first = 1'b0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model_running[%0d]", i), int'(running[i]), int'(m_rem[i] > 0));
            chk($sformatf("model_expired[%0d]", i), int'(expired[i]), int'(m_exp[i]));
            chk($sformatf("model_ticks[%0d]", i), int'(ticks_left[i]), (m_rem[i] + p_of(i) - 1) / p_of(i));
            chk($sformatf("model_win[%0d]", i), int'(win_count[i]), m_win[i]);
            chk($sformatf("model_loss[%0d]", i), int'(loss_count[i]), m_loss[i]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NI; i++) begin
            start[i]       = 1'b0;
            game_won[i]    = 1'b0;
            clear_score[i] = 1'b0;
        end
    endtask

    initial begin
        int rst_hold;
        idle_inputs();
        rst = 1'b0;
        repeat (3) step();
        chk("reset_running", int'(running[0]), 0);
        chk("reset_ticks", int'(ticks_left[0]), 0);
        chk("reset_win", int'(win_count[0]), 0);
        rst = 1'b1;
        step();

        // Single game won: 12 cycles of running, ticks 3,2,1,0 every 4 cycles.
        start[0] = 1'b1; game_won[0] = 1'b1;
        step();
        start[0] = 1'b0; game_won[0] = 1'b0;
        chk("won_running", int'(running[0]), 1);
        chk("won_ticks_e0", int'(ticks_left[0]), 3);
        chk("won_win", int'(win_count[0]), 1);
        chk("won_loss", int'(loss_count[0]), 0);
        repeat (3) step();
        chk("won_ticks_e3", int'(ticks_left[0]), 3);
        step();
        chk("won_ticks_e4", int'(ticks_left[0]), 2);
        repeat (4) step();
        chk("won_ticks_e8", int'(ticks_left[0]), 1);
        repeat (3) step();
        chk("won_running_e11", int'(running[0]), 1);
        chk("won_expired_e11", int'(expired[0]), 0);
        step();
        chk("won_running_e12", int'(running[0]), 0);
        chk("won_expired_e12", int'(expired[0]), 1);
        chk("won_ticks_e12", int'(ticks_left[0]), 0);
        step();
        chk("won_expired_e13", int'(expired[0]), 0);

        // Lost game, with a retrigger attempt 5 cycles in that must be ignored.
        start[0] = 1'b1; game_won[0] = 1'b0;
        step();
        start[0] = 1'b0;
        repeat (4) step();
        start[0] = 1'b1; game_won[0] = 1'b1;
        step();
        start[0] = 1'b0; game_won[0] = 1'b0;
        chk("retrig_win", int'(win_count[0]), 1);
        chk("retrig_loss", int'(loss_count[0]), 1);
        repeat (6) step();
        chk("retrig_running_e11", int'(running[0]), 1);
        step();
        chk("retrig_running_e12", int'(running[0]), 0);
        chk("retrig_expired_e12", int'(expired[0]), 1);

        // Start on the expired cycle is accepted: a single low cycle, then 12 more.
        start[0] = 1'b1; game_won[0] = 1'b1;
        step();
        start[0] = 1'b0; game_won[0] = 1'b0;
        chk("back2back_running", int'(running[0]), 1);
        chk("back2back_win", int'(win_count[0]), 2);
        repeat (11) step();
        chk("back2back_running_e11", int'(running[0]), 1);
        step();
        chk("back2back_running_e12", int'(running[0]), 0);
        chk("back2back_expired_e12", int'(expired[0]), 1);
        step();

        // Clear and start together: counters clear, timer still starts.
        clear_score[0] = 1'b1; start[0] = 1'b1; game_won[0] = 1'b1;
        step();
        idle_inputs();
        chk("clear_start_running", int'(running[0]), 1);
        chk("clear_start_win", int'(win_count[0]), 0);
        chk("clear_start_loss", int'(loss_count[0]), 0);
        repeat (12) step();

        // Saturation on the one-cycle instance; stray game_won between starts must not count.
        for (int k = 0; k < 256; k++) begin
            start[1] = 1'b1; game_won[1] = 1'b0;
            step();
            start[1] = 1'b0; game_won[1] = 1'($urandom);
            step();
        end
        game_won[1] = 1'b0;
        chk("sat_loss", int'(loss_count[1]), 255);
        chk("sat_win", int'(win_count[1]), 0);

        // Reset six cycles into a pause: immediate abort, no expired pulse.
        start[0] = 1'b1; game_won[0] = 1'b1;
        step();
        start[0] = 1'b0; game_won[0] = 1'b0;
        repeat (5) step();
        chk("pre_rst_running", int'(running[0]), 1);
        rst = 1'b0;
        #1;
        chk("rst_running", int'(running[0]), 0);
        chk("rst_ticks", int'(ticks_left[0]), 0);
        chk("rst_expired", int'(expired[0]), 0);
        chk("rst_win", int'(win_count[0]), 0);
        chk("rst_loss_b", int'(loss_count[1]), 0);

        // Start held through reset is rejected on the first edge after release.
        start[0] = 1'b1; game_won[0] = 1'b1;
        repeat (2) step();
        rst = 1'b1;
        step();
        start[0] = 1'b0; game_won[0] = 1'b0;
        chk("held_start_running", int'(running[0]), 0);
        chk("held_start_win", int'(win_count[0]), 0);
        // A start that rises only after release is accepted on the first edge.
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("fresh_start_running", int'(running[0]), 1);
        chk("fresh_start_loss", int'(loss_count[0]), 1);
        repeat (14) step();

        // Random traffic on both instances, with occasional resets and clears.
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                start[i]       = ($urandom_range(3) == 0);
                game_won[i]    = 1'($urandom);
                clear_score[i] = ($urandom_range(39) == 0);
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b1;
            end else if ($urandom_range(499) == 0) begin
                rst_hold = $urandom_range(3, 1);
                rst = 1'b0;
            end
            step();
        end
        idle_inputs();
        rst = 1'b1;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
